quad_pulse_gen: RTL
===================

QUAD_PULSE_GEN -- requirements
Module: quad_pulse_gen

Interface
REQ-001 SHALL have parameter PRESCALE, default 1024: clock cycles per timer unit (sim benches use 4).
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port START  input  1  command strobe, sampled only in IDLE.
REQ-005 SHALL have port DIR  input  1  0 = forward (A leads B), 1 = reverse (B leads A).
REQ-006 SHALL have port STEPS  input  8  number of quadrature steps to emit (0..255).
REQ-007 SHALL have port DIV  input  4  step period select; period T = (DIV+1)*PRESCALE clocks.
REQ-008 SHALL have port A  output  1  quadrature channel A, registered.
REQ-009 SHALL have port B  output  1  quadrature channel B, registered.
REQ-010 SHALL have port BUSY  output  1  high while a command is executing.
REQ-011 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-012 SHALL have port POS  output  8  emitted-position counter, modulo 256.

Function
REQ-013 SHALL implement states IDLE and RUN only; DONE is a registered flag, not a state.
REQ-014 SHALL, in IDLE on an edge with START=1 and STEPS!=0, latch STEPS/DIR/DIV, load timer with T, enter RUN, set BUSY=1 from that edge.
REQ-015 SHALL, in IDLE on an edge with START=1 and STEPS=0, remain IDLE, keep BUSY=0, leave A/B/POS unchanged, assert DONE for the following cycle.
REQ-016 SHALL, for a command accepted at edge k, apply step n (n=1..STEPS) at edge k+n*T exactly.
REQ-017 SHALL step {A,B} forward as 00->10->11->01->00 and reverse as 00->01->11->10->00; exactly one output toggles per step.
REQ-018 SHALL increment POS (DIR=0) or decrement POS (DIR=1) by 1 per step, wrapping 255<->0.
REQ-019 SHALL, at the edge applying the last step, return to IDLE, clear BUSY, and set DONE=1 for exactly one cycle.
REQ-020 SHALL accept a new START in the cycle DONE is high (back-to-back commands, no gap cycle).
REQ-021 SHALL ignore START, DIR, STEPS, DIV changes while in RUN.
REQ-022 SHALL retain A/B phase and POS across commands; each command continues from the current phase.
REQ-023 SHALL size the timer as clog2(16*PRESCALE) bits; no overflow for DIV=15.

Reset
REQ-024 SHALL, on RST=1 at any time including mid-RUN, immediately force state=IDLE, A=0, B=0, POS=0, BUSY=0, DONE=0, timer=0, step counter=0.
REQ-025 SHALL ignore START while RST=1; the first accept is the first rising edge after RST deasserts.

Structure
REQ-026 SHALL take state encoding (IDLE, RUN) and the forward/reverse phase-sequence constants from shared package quad_gen_pkg.
REQ-027 SHALL instantiate one sub-module quad_step_timer (loadable down-counter emitting a one-cycle tick at T).
REQ-028 SHALL keep the top at 120-400 lines RTL; no multipliers beyond the constant (DIV+1)*PRESCALE.

Verification (PRESCALE=4)
REQ-029 SHALL test: reset, START at edge k, STEPS=4, DIR=0, DIV=0 -> {A,B}=10,11,01,00 at k+4,+8,+12,+16; POS=4; DONE high one cycle after k+16; BUSY low.
REQ-030 SHALL test: from reset, STEPS=3, DIR=1, DIV=1 -> {A,B}=01,11,10 at k+8,+16,+24; POS=253; DONE once.
REQ-031 SHALL test: START with STEPS=0 -> DONE=1 next cycle only, BUSY stays 0, A/B/POS unchanged.
REQ-032 SHALL test: START pulses during RUN with different STEPS -> ignored; step count and timing per original command.
REQ-033 SHALL test: RST asserted after step 2 of a 10-step run -> A=B=0, POS=0, BUSY=0 without waiting for a clock edge; no DONE pulse.
REQ-034 SHALL test: POS=255 (reach via 255 forward steps), then 1 forward step -> POS=0; START in DONE cycle accepted with zero idle gap.

Source files
------------

// File: rtl/quad_gen_pkg.sv
// Shared types and phase tables for the quadrature pulse generator.
package quad_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Next {A,B} indexed by the current {A,B} (2 bits per entry, entry 0 in LSBs).
  // Forward cycle: 00->10->11->01->00
  localparam logic [7:0] FWD_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};
  // Reverse cycle: 00->01->11->10->00
  localparam logic [7:0] REV_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

  function automatic logic [1:0] next_ab(input logic [1:0] ab, input logic dir);
    logic [2:0] idx;
    idx = {ab, 1'b0};
    return dir ? REV_NEXT[idx +: 2] : FWD_NEXT[idx +: 2];
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable down-counter; tick is high for the one cycle the count sits at zero
// while enabled, so loading T-1 gives a tick every T clocks.
module quad_step_timer #(
  parameter int TW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [TW-1:0] load_val,
  output logic          tick
);

  logic [TW-1:0] cnt;

  // Reload on request, otherwise count down to zero while enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign tick = en && (cnt == '0);

endmodule

// File: rtl/quad_pulse_gen.sv
// Quadrature step generator: emits STEPS A/B phase steps, one every
// (DIV+1)*PRESCALE clocks, tracking a modulo-256 position.
module quad_pulse_gen
  import quad_gen_pkg::*;
#(
  parameter int PRESCALE = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       DIR,
  input  logic [7:0] STEPS,
  input  logic [3:0] DIV,
  output logic       A,
  output logic       B,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] POS
);

  // Timer holds T-1, so 16*PRESCALE-1 is the largest value it ever sees.
  localparam int TW = $clog2(16 * PRESCALE);

  function automatic logic [TW-1:0] period_m1(input logic [3:0] d);
    return TW'((int'(d) + 1) * PRESCALE - 1);
  endfunction

  state_t        state, nxt;
  logic [7:0]    rem;
  logic [7:0]    pos;
  logic [1:0]    ab;
  logic          dir_q;
  logic [3:0]    div_q;
  logic          tick, load, accept, zcmd, step, fin;
  logic [TW-1:0] load_val;

  quad_step_timer #(.TW(TW)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .en       (state == RUN),
    .load_val (load_val),
    .tick     (tick)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= nxt;
  end

  // Next state, command accept and step/reload decisions
  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = period_m1(div_q);
    accept   = 1'b0;
    zcmd     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    case (state)
      IDLE: begin
        if (START) begin
          if (STEPS != 8'd0) begin
            accept   = 1'b1;
            load     = 1'b1;
            load_val = period_m1(DIV);
            nxt      = RUN;
          end else begin
            zcmd = 1'b1;
          end
        end
      end
      RUN: begin
        if (tick) begin
          step = 1'b1;
          if (rem == 8'd1) begin
            fin = 1'b1;
            nxt = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Command latch, phase/position stepping and status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rem   <= '0;
      pos   <= '0;
      ab    <= 2'b00;
      dir_q <= 1'b0;
      div_q <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
    end else begin
      DONE <= zcmd | fin;
      BUSY <= (nxt == RUN);
      if (accept) begin
        rem   <= STEPS;
        dir_q <= DIR;
        div_q <= DIV;
      end
      if (step) begin
        ab  <= next_ab(ab, dir_q);
        pos <= dir_q ? pos - 8'd1 : pos + 8'd1;
        rem <= rem - 8'd1;
      end
    end
  end

  assign A   = ab[1];
  assign B   = ab[0];
  assign POS = pos;

endmodule
